inside_range: RTL and testbench

- Pipelined geometric range check: decides whether point P=(xP,yP) lies inside or on the circle of radius rJ centred at J=(xJ,yJ).
- Used by the trilateration/localisation datapath to test a candidate position against one anchor's range circle.
- Comparison is on squared Euclidean distance; no square root.

---
 rtl/inside_range_pkg.sv | 16 +
 rtl/inside_range_sq.sv | 14 +
 rtl/inside_range.sv | 77 +++++++
 tb/tb_inside_range.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/inside_range_pkg.sv
// Shared widths and the stage-1 register layout for the inside_range point-in-circle check.
package inside_range_pkg;

  localparam int N_DEF = 8;
  localparam int DW    = N_DEF + 3;      // signed coordinate difference
  localparam int SQW   = 2 * N_DEF + 6;  // square of a difference
  localparam int SUMW  = 2 * N_DEF + 7;  // sum of the two squares

  typedef struct packed {
    logic                 valid;
    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic [N_DEF:0]       rj;
  } s1_t;

endpackage

// File: rtl/inside_range_sq.sv
// Combinational squarer: signed W-bit operand in, exact unsigned 2W-bit square out.
module inside_range_sq #(
  parameter int W = 11
) (
  input  logic signed [W-1:0]   a,
  output logic        [2*W-1:0] sq
);

  logic signed [2*W-1:0] prod;

  assign prod = (2*W)'(a) * (2*W)'(a);
  assign sq   = $unsigned(prod);

endmodule

// File: rtl/inside_range.sv
// Two-stage pipelined test of whether P lies inside or on the circle of radius rJ around J.
// Optional `define INSIDE_RANGE_DIST_EN adds the registered squared distance on dist_sq.
module inside_range
  import inside_range_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [N+1:0] xP,
  input  logic signed [N+1:0] yP,
  input  logic signed [N-1:0] xJ,
  input  logic signed [N-1:0] yJ,
  input  logic        [N:0]   rJ,
  output logic                out_valid,
  output logic                in_range
`ifdef INSIDE_RANGE_DIST_EN
  ,
  output logic [2*N+6:0]      dist_sq
`endif
);

  s1_t                  s1;
  logic signed [DW-1:0] dx_c;
  logic signed [DW-1:0] dy_c;
  logic [SQW-1:0]       dx_sq;
  logic [SQW-1:0]       dy_sq;
  logic [2*N+3:0]       r_sq;
  logic [SUMW-1:0]      sum;
  logic                 in_range_c;

  assign dx_c = DW'(xP) - DW'(xJ);
  assign dy_c = DW'(yP) - DW'(yJ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.dx <= dx_c;
        s1.dy <= dy_c;
        s1.rj <= rJ;
      end
    end
  end

  inside_range_sq #(.W(DW)) u_sq_dx (.a(s1.dx), .sq(dx_sq));
  inside_range_sq #(.W(DW)) u_sq_dy (.a(s1.dy), .sq(dy_sq));
  // Radius is unsigned: prepend a zero sign bit so the signed squarer can be reused.
  inside_range_sq #(.W(N+2)) u_sq_r (.a($signed({1'b0, s1.rj})), .sq(r_sq));

  always_comb begin
    sum        = SUMW'(dx_sq) + SUMW'(dy_sq);
    in_range_c = (sum <= SUMW'(r_sq));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_range  <= 1'b0;
`ifdef INSIDE_RANGE_DIST_EN
      dist_sq   <= '0;
`endif
    end else begin
      out_valid <= s1.valid;
      if (s1.valid) begin
        in_range <= in_range_c;
`ifdef INSIDE_RANGE_DIST_EN
        dist_sq  <= sum;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inside_range.sv
// Directed self-checking bench for inside_range: isolated vectors, streaming with bubbles, async reset.
module tb_inside_range;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [9:0] xP = '0;
  logic signed [9:0] yP = '0;
  logic signed [7:0] xJ = '0;
  logic signed [7:0] yJ = '0;
  logic        [8:0] rJ = '0;
  logic              out_valid;
  logic              in_range;
`ifdef INSIDE_RANGE_DIST_EN
  logic [22:0]       dist_sq;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  inside_range #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .xP        (xP),
    .yP        (yP),
    .xJ        (xJ),
    .yJ        (yJ),
    .rJ        (rJ),
    .out_valid (out_valid),
    .in_range  (in_range)
`ifdef INSIDE_RANGE_DIST_EN
    ,
    .dist_sq   (dist_sq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int xp, yp, xj, yj, rj;
    bit exp_in;
    int exp_sum;
  } vec_t;

  // Hand-computed expectations: A, B, C, three boundary cases, extreme corner.
  vec_t vecs [7] = '{
    '{ 151, -276,  -32,  108, 215, 1'b0, 180945},
    '{-231,    5,  109,  -99, 183, 1'b0, 126416},
    '{ -72, -102,  -16, -111, 236, 1'b1,   3217},
    '{   3,    4,    0,    0,   5, 1'b1,     25},
    '{   3,    4,    0,    0,   4, 1'b0,     25},
    '{   0,    0,    0,    0,   0, 1'b1,      0},
    '{-512,  511,  127, -128, 511, 1'b0, 816642}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx);
    if (idx < 0) begin
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1;
      xP = 10'(vecs[idx].xp);
      yP = 10'(vecs[idx].yp);
      xJ = 8'(vecs[idx].xj);
      yJ = 8'(vecs[idx].yj);
      rJ = 9'(vecs[idx].rj);
    end
  endtask

  task automatic run_single(input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(idx);
    @(negedge clk);
    drive(-1);
    check({t, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({t, "_valid"}, 32'(out_valid), 32'd1);
    check({t, "_in_range"}, 32'(in_range), 32'(vecs[idx].exp_in));
`ifdef INSIDE_RANGE_DIST_EN
    check({t, "_dist_sq"}, 32'(dist_sq), 32'(vecs[idx].exp_sum));
`endif
    @(negedge clk);
    check({t, "_bubble_valid"}, 32'(out_valid), 32'd0);
    check({t, "_hold_in_range"}, 32'(in_range), 32'(vecs[idx].exp_in));
  endtask

  // -1 marks a bubble cycle
  int stream [12] = '{0, 1, 2, -1, 2, -1, -1, 3, 4, 5, -1, -1};

  initial begin
    bit s1_v, s2_v;
    bit s1_r, s2_r;

    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_range", 32'(in_range), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_single(i);

    s1_v = 1'b0; s2_v = 1'b0; s1_r = 1'b0; s2_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(stream[i]);
      @(negedge clk);
      s2_v = s1_v; s2_r = s1_r;
      s1_v = (stream[i] >= 0);
      s1_r = (stream[i] >= 0) ? vecs[stream[i]].exp_in : 1'b0;
      check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'(s2_v));
      if (s2_v) check($sformatf("stream%0d_in_range", i), 32'(in_range), 32'(s2_r));
    end

    drive(2);
    @(negedge clk);
    drive(2);
    @(negedge clk);
    drive(-1);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_in_range", 32'(in_range), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_in_range", 32'(in_range), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d_valid", i), 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
